// File: rtl/wb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_slave
// Description : Wishbone classic register file for the UART block. It has
//               byte-lane writes, wait states, read-only registers, ERR
//               termination and a hardware update port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_slave #(
    parameter int                  DATA_W      = 32,
    parameter int                  SEL_W       = DATA_W / 8,
    parameter int                  ADDR_W      = 3,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                         WBCLK,
    input  logic                         WBRST,
    input  logic [ADDR_W-1:0]            WB_ADDR,
    input  logic [SEL_W-1:0]             WB_SEL,
    input  logic [DATA_W-1:0]            WB_DAT_I,
    output logic [DATA_W-1:0]            WB_DAT_O,
    input  logic                         WB_WE,
    input  logic                         WB_STB,
    input  logic                         WB_CYC,
    output logic                         WB_ACK,
    output logic                         WB_ERR,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_wait  = 2'd1;
    localparam logic [1:0] c_term  = 2'd2;
    localparam int         c_depth = 2 ** ADDR_W;
    // The counter runs from WAIT_STATES-1 down to 0 so that TERM lands in cycle WAIT_STATES+1.
    localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] w_q      [NUM_REGS];
    logic [DATA_W-1:0] w_rd_vec [c_depth];
    logic [c_depth-1:0] w_ro_vec;
    logic              w_req;
    logic              w_commit;
    logic              w_addr_ok;
    logic              w_err;
    logic              w_bus_wr;

    assign w_req     = WB_STB & WB_CYC;
    assign w_commit  = w_req & (((r_state == c_idle) && (WAIT_STATES == 0)) ||
                                ((r_state == c_wait) && (r_cnt == 4'd0)));
    assign w_addr_ok = (32'(WB_ADDR) < 32'(NUM_REGS));
    assign w_err     = ~w_addr_ok | (WB_WE & w_ro_vec[WB_ADDR]);
    assign w_bus_wr  = w_commit & WB_WE & ~w_err;

    // Full address map; unimplemented words read as zero and are never read-only.
    generate
        for (genvar i = 0; i < c_depth; i++) begin : g_dec
            if (i < NUM_REGS) begin : g_impl
                assign w_ro_vec[i] = RO_MASK[i];
                assign w_rd_vec[i] = w_q[i];
            end else begin : g_hole
                assign w_ro_vec[i] = 1'b0;
                assign w_rd_vec[i] = '0;
            end
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            logic [DATA_W-1:0] r_q;
            logic              w_hit;

            assign w_hit = w_bus_wr && (WB_ADDR == ADDR_W'(i));

            // Bus data wins on selected lanes, hardware data fills the rest.
            always_ff @(posedge WBCLK) begin
                if (!WBRST) begin
                    r_q <= '0;
                end else begin
                    for (int b = 0; b < SEL_W; b++) begin
                        if (w_hit && WB_SEL[b]) begin
                            r_q[8*b +: 8] <= WB_DAT_I[8*b +: 8];
                        end else if (hw_we[i]) begin
                            r_q[8*b +: 8] <= hw_wdata[i*DATA_W + 8*b +: 8];
                        end
                    end
                end
            end

            assign w_q[i]                    = r_q;
            assign reg_q[i*DATA_W +: DATA_W] = r_q;
        end
    endgenerate

    always_ff @(posedge WBCLK) begin
        if (!WBRST) begin
            r_state  <= c_idle;
            r_cnt    <= 4'd0;
            WB_ACK   <= 1'b0;
            WB_ERR   <= 1'b0;
            WB_DAT_O <= '0;
        end else begin
            WB_ACK   <= 1'b0;
            WB_ERR   <= 1'b0;
            WB_DAT_O <= '0;
            case (r_state)
                c_idle: begin
                    if (w_req && (WAIT_STATES != 0)) begin
                        r_state <= c_wait;
                        r_cnt   <= c_wait_load;
                    end
                end
                c_wait: begin
                    if (!w_req) begin
                        r_state <= c_idle;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_term:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
            if (w_commit) begin
                r_state <= c_term;
                WB_ACK  <= ~w_err;
                WB_ERR  <= w_err;
                if (!WB_WE && w_addr_ok) begin
                    WB_DAT_O <= w_rd_vec[WB_ADDR];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile_slave
// Description : Self-checking bench for wb_regfile_slave, directed plus random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_slave;

    localparam int         DW = 32;
    localparam int         AW = 3;
    localparam int         NR = 6;
    localparam int         WS = 2;
    localparam logic [5:0] RO = 6'b100000;

    logic              clk = 1'b0;
    logic              rstn;
    logic [AW-1:0]     addr;
    logic [3:0]        sel;
    logic [DW-1:0]     dat_i;
    logic [DW-1:0]     dat_o;
    logic              we, stb, cyc, ack, err;
    logic [NR-1:0]     hw_we;
    logic [NR*DW-1:0]  hw_wdata;
    logic [NR*DW-1:0]  reg_q;

    logic [DW-1:0]     model [NR];
    logic [7:0]        ro_v;
    int                total = 0;
    int                bad   = 0;

    always #5 clk = ~clk;

    wb_regfile_slave #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_STATES(WS), .RO_MASK(RO)
    ) dut (
        .WBCLK(clk), .WBRST(rstn), .WB_ADDR(addr), .WB_SEL(sel), .WB_DAT_I(dat_i),
        .WB_DAT_O(dat_o), .WB_WE(we), .WB_STB(stb), .WB_CYC(cyc), .WB_ACK(ack),
        .WB_ERR(err), .hw_we(hw_we), .hw_wdata(hw_wdata), .reg_q(reg_q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) chk($sformatf("%s_reg%0d", tag, i), 64'(reg_q[i*DW +: DW]), 64'(model[i]));
    endtask

    // One complete access; optional hardware write to reg hidx on the commit edge.
    task automatic access(input string tag, input logic [2:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, input logic hcol, input int hidx, input logic [31:0] hdat);
        int ack_at, err_at, terms;
        logic [31:0] rd, after, exp_rd;
        logic exp_err;
        exp_err = (a >= NR) ? 1'b1 : (w && ro_v[a]);
        exp_rd  = (!w && !exp_err) ? model[a] : 32'h0;
        ack_at = 0; err_at = 0; terms = 0; rd = 32'h0; after = 32'hFFFF_FFFF;
        addr = a; we = w; sel = s; dat_i = d; stb = 1'b1; cyc = 1'b1;
        for (int k = 1; k <= WS + 3; k++) begin
            tick();
            if (ack) begin ack_at = k; terms++; rd = dat_o; end
            if (err) begin err_at = k; terms++; rd = dat_o; end
            if (ack || err) begin stb = 1'b0; cyc = 1'b0; end
            if (k == WS + 2) after = dat_o;
            if (hcol && k == WS) begin
                hw_we[hidx] = 1'b1;
                hw_wdata[hidx*DW +: DW] = hdat;
            end
            if (k == WS + 1) hw_we = '0;
        end
        stb = 1'b0; cyc = 1'b0;
        chk({tag, "_ack_cycle"}, 64'(ack_at), exp_err ? 64'd0 : 64'(WS + 1));
        chk({tag, "_err_cycle"}, 64'(err_at), exp_err ? 64'(WS + 1) : 64'd0);
        chk({tag, "_terms"}, 64'(terms), 64'd1);
        chk({tag, "_dat_o"}, 64'(rd), 64'(exp_rd));
        chk({tag, "_dat_o_after"}, 64'(after), 64'd0);
        if (hcol) model[hidx] = hdat;
        if (w && !exp_err)
            for (int b = 0; b < 4; b++) if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
        check_regs(tag);
    endtask

    initial begin
        int acks, errs, ack_mask, ack_at;
        logic [NR-1:0] m;
        ro_v = {2'b00, RO};
        rstn = 1'b0; addr = '0; sel = '0; dat_i = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
        hw_we = '0; hw_wdata = '0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        repeat (3) tick();
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_dat_o", 64'(dat_o), 64'd0);
        check_regs("reset");
        rstn = 1'b1;
        tick();

        access("wr_full", 3'd1, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 0, 32'h0);
        access("wr_lanes", 3'd1, 1'b1, 4'b0101, 32'h11223344, 1'b0, 0, 32'h0);
        chk("lanes_value", 64'(reg_q[1*DW +: DW]), 64'h0000_0000_DE22_BE44);
        access("rd_lanes", 3'd1, 1'b0, 4'h0, 32'h0, 1'b0, 0, 32'h0);
        access("wr_ro", 3'd5, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 0, 32'h0);
        access("wr_oob", 3'd6, 1'b1, 4'hF, 32'h12345678, 1'b0, 0, 32'h0);
        access("rd_oob", 3'd7, 1'b0, 4'hF, 32'h0, 1'b0, 0, 32'h0);
        access("wr_sel0", 3'd1, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, 0, 32'h0);
        access("collide", 3'd2, 1'b1, 4'b0011, 32'h0000AAAA, 1'b1, 2, 32'h55555555);
        chk("collide_value", 64'(reg_q[2*DW +: DW]), 64'h0000_0000_5555_AAAA);

        // Hardware port writes a read-only register; the bus then reads it back.
        hw_we = 6'b100000; hw_wdata[5*DW +: DW] = 32'hA5A5_0F0F;
        tick(); hw_we = '0; model[5] = 32'hA5A5_0F0F;
        access("rd_ro", 3'd5, 1'b0, 4'h0, 32'h0, 1'b0, 0, 32'h0);

        // Abort: strobe drops in cycle 1 of a write.
        addr = 3'd3; we = 1'b1; sel = 4'hF; dat_i = 32'h0BAD_0BAD; stb = 1'b1; cyc = 1'b1;
        tick(); stb = 1'b0; cyc = 1'b0;
        acks = 0; errs = 0;
        for (int k = 0; k < 5; k++) begin tick(); acks += int'(ack); errs += int'(err); end
        chk("abort_acks", 64'(acks), 64'd0);
        chk("abort_errs", 64'(errs), 64'd0);
        check_regs("abort");
        access("after_abort", 3'd3, 1'b1, 4'hF, 32'h600D_600D, 1'b0, 0, 32'h0);

        // Held strobe: two accesses back to back, one ACK each.
        addr = 3'd1; we = 1'b0; sel = 4'h0; stb = 1'b1; cyc = 1'b1; ack_mask = 0; errs = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (ack) ack_mask |= (1 << k);
            errs += int'(err);
        end
        stb = 1'b0; cyc = 1'b0;
        chk("held_ack_pattern", 64'(ack_mask), 64'((1 << 3) | (1 << 7)));
        chk("held_errs", 64'(errs), 64'd0);
        repeat (2) tick();

        // Reset lands in cycle 2 of a write with STB held throughout.
        addr = 3'd4; we = 1'b1; sel = 4'hF; dat_i = 32'h7777_1234; stb = 1'b1; cyc = 1'b1;
        tick(); tick();
        rstn = 1'b0;
        tick();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        chk("rst_mid_ack", 64'(ack), 64'd0);
        chk("rst_mid_err", 64'(err), 64'd0);
        chk("rst_mid_dat_o", 64'(dat_o), 64'd0);
        check_regs("rst_mid");
        rstn = 1'b1;
        acks = 0; ack_at = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (ack) begin acks++; ack_at = k; stb = 1'b0; cyc = 1'b0; end
        end
        stb = 1'b0; cyc = 1'b0;
        chk("rst_restart_acks", 64'(acks), 64'd1);
        chk("rst_restart_cycle", 64'(ack_at), 64'(WS + 1));
        model[4] = 32'h7777_1234;
        check_regs("rst_restart");

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                m = NR'($urandom);
                hw_we = m;
                for (int i = 0; i < NR; i++) begin
                    hw_wdata[i*DW +: DW] = $urandom;
                    if (m[i]) model[i] = hw_wdata[i*DW +: DW];
                end
                tick(); hw_we = '0;
            end
            access($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom),
                   $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, NR - 1), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
